// File: rtl/parity_rr_sched.sv
// rtl/parity_rr_sched.sv - round-robin shared serial parity engine; optional PARITY_SCHED_STATS_EN adds response counters
module parity_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_parity,
  output logic [ID_W-1:0]           rsp_id,
`ifdef PARITY_SCHED_STATS_EN
  output logic [15:0]               stat_count,
  output logic [15:0]               stat_odd,
`endif
  output logic                      busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                acc_q;
  logic [DATA_W-1:0]   shift_q;
  logic                rsp_valid_q;
  logic                rsp_parity_q;
  logic [ID_W-1:0]     rsp_id_q;

  logic [ID_W-1:0]     grant, grant_lo, grant_hi;
  logic                any_lo, any_hi;
  logic                accept;
  logic                rsp_fire;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    grant_lo = '0;
    grant_hi = '0;
    any_lo   = 1'b0;
    any_hi   = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_lo = ID_W'(i);
        any_lo   = 1'b1;
        if (ID_W'(i) >= rr_ptr_q) begin
          grant_hi = ID_W'(i);
          any_hi   = 1'b1;
        end
      end
    end
    grant = any_hi ? grant_hi : grant_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_lo) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      shift_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_parity_q <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q  <= req_data[int'(grant)*DATA_W +: DATA_W];
            rsp_id_q <= grant;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= (grant == ID_LAST) ? '0 : grant + 1'b1;
          end
        end
        CALC: begin
          acc_q   <= acc_q ^ shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          // Last bit folds straight into the result so the response appears on this edge.
          if (cnt_q == CNT_LAST) begin
            rsp_parity_q <= acc_q ^ shift_q[0];
            rsp_valid_q  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_parity = rsp_parity_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != IDLE);

`ifdef PARITY_SCHED_STATS_EN
  logic [15:0] stat_count_q;
  logic [15:0] stat_odd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count_q <= '0;
      stat_odd_q   <= '0;
    end else if (rsp_fire) begin
      if (stat_count_q != 16'hFFFF) begin
        stat_count_q <= stat_count_q + 16'd1;
      end
      if (rsp_parity_q && (stat_odd_q != 16'hFFFF)) begin
        stat_odd_q <= stat_odd_q + 16'd1;
      end
    end
  end

  assign stat_count = stat_count_q;
  assign stat_odd   = stat_odd_q;
`endif

endmodule
